// File: rtl/rob_pkg.sv
// Shared sizing constants and the reorder-buffer entry layout.
package rob_pkg;

  localparam int DEPTH  = 16;
  localparam int TAG_W  = 5;
  localparam int AREG_N = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RW_W   = $clog2(AREG_N);

  typedef struct packed {
    logic             valid;
    logic             done;
    logic             mispredict;
    logic             regwr;
    logic [RW_W-1:0]  rw;
    logic [TAG_W-1:0] tag_new;
    logic [TAG_W-1:0] tag_old;
  } rob_entry_t;

endpackage

// File: rtl/rob_arf_map.sv
// Committed architectural-to-physical map; resets to the identity mapping.
module arf_map
  import rob_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [RW_W-1:0]               Rw,
  input  logic [TAG_W-1:0]              tag,
  output logic [AREG_N-1:0][TAG_W-1:0]  ARF_tag
);

  logic [AREG_N-1:0][TAG_W-1:0] map_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < AREG_N; i++) map_q[i] <= TAG_W'(i);
    end else if (we) begin
      map_q[Rw] <= tag;
    end
  end

  assign ARF_tag = map_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate/retire, out-of-order completion, and a
// one-cycle stop pulse after a mispredicted branch retires.
module rob
  import rob_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          freeze_front,
  input  logic                          valid_alloc,
  input  logic                          RegWr_alloc,
  input  logic [RW_W-1:0]               Rw_alloc,
  input  logic [TAG_W-1:0]              tag_PRF_alloc,
  input  logic [TAG_W-1:0]              tag_Rw_old_alloc,
  output logic [PTR_W-1:0]              tag_ROB,
  output logic                          full_ROB,
  input  logic                          valid_Result_add,
  input  logic [PTR_W-1:0]              tag_ROB_add,
  input  logic                          mispredict_add,
  input  logic                          valid_Result_mul,
  input  logic [PTR_W-1:0]              tag_ROB_mul,
  output logic                          RegWr_ARF,
  output logic [TAG_W-1:0]              tag_PRF_ARF,
  output logic [TAG_W-1:0]              tag_Rw_old,
  output logic [AREG_N-1:0][TAG_W-1:0]  ARF_tag,
  output logic                          stop
);

  rob_entry_t             entries_q [DEPTH];
  rob_entry_t             entries_d [DEPTH];
  logic       [PTR_W-1:0] head_q, head_d;
  logic       [PTR_W-1:0] tail_q, tail_d;
  logic       [CNT_W-1:0] count_q, count_d;
  logic                   stop_q, stop_d;

  rob_entry_t head;
  logic       commit, flush, alloc;

  assign head     = entries_q[head_q];
  assign full_ROB = (count_q == CNT_W'(DEPTH));
  assign tag_ROB  = tail_q;
  assign stop     = stop_q;
  assign commit   = !stop_q && head.valid && head.done;
  assign flush    = commit && head.mispredict;
  assign alloc    = valid_alloc && !freeze_front && !full_ROB && !stop_q;

  // Gated by commit so the PRF never frees a tag from an unretired entry.
  assign RegWr_ARF   = commit && head.regwr;
  assign tag_PRF_ARF = (commit && head.regwr) ? head.tag_new : '0;
  assign tag_Rw_old  = commit ? head.tag_old : '0;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    stop_d    = 1'b0;
    if (!stop_q) begin
      if (valid_Result_add && entries_q[tag_ROB_add].valid) begin
        entries_d[tag_ROB_add].done       = 1'b1;
        entries_d[tag_ROB_add].mispredict = mispredict_add;
      end
      if (valid_Result_mul && entries_q[tag_ROB_mul].valid) begin
        entries_d[tag_ROB_mul].done = 1'b1;
      end
      if (commit) begin
        entries_d[head_q] = '0;
        head_d            = head_q + PTR_W'(1);
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        stop_d  = 1'b1;
      end else begin
        if (alloc) begin
          entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                regwr: RegWr_alloc, rw: Rw_alloc,
                                tag_new: tag_PRF_alloc, tag_old: tag_Rw_old_alloc};
          tail_d = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(commit);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stop_q  <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      stop_q    <= stop_d;
    end
  end

  arf_map u_arf_map (
    .clk     (clk),
    .rst     (rst),
    .we      (commit && head.regwr),
    .Rw      (head.rw),
    .tag     (head.tag_new),
    .ARF_tag (ARF_tag)
  );

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: retire order, full/wrap, non-writing retire,
// mispredict flush and dual writeback.
module tb_rob;
  import rob_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic                         freeze_front = 1'b0;
  logic                         valid_alloc = 1'b0;
  logic                         RegWr_alloc = 1'b0;
  logic [RW_W-1:0]              Rw_alloc = '0;
  logic [TAG_W-1:0]             tag_PRF_alloc = '0;
  logic [TAG_W-1:0]             tag_Rw_old_alloc = '0;
  logic [PTR_W-1:0]             tag_ROB;
  logic                         full_ROB;
  logic                         valid_Result_add = 1'b0;
  logic [PTR_W-1:0]             tag_ROB_add = '0;
  logic                         mispredict_add = 1'b0;
  logic                         valid_Result_mul = 1'b0;
  logic [PTR_W-1:0]             tag_ROB_mul = '0;
  logic                         RegWr_ARF;
  logic [TAG_W-1:0]             tag_PRF_ARF;
  logic [TAG_W-1:0]             tag_Rw_old;
  logic [AREG_N-1:0][TAG_W-1:0] ARF_tag;
  logic                         stop;

  int n_chk  = 0;
  int n_pass = 0;

  rob dut (
    .clk(clk), .rst(rst), .freeze_front(freeze_front), .valid_alloc(valid_alloc),
    .RegWr_alloc(RegWr_alloc), .Rw_alloc(Rw_alloc), .tag_PRF_alloc(tag_PRF_alloc),
    .tag_Rw_old_alloc(tag_Rw_old_alloc), .tag_ROB(tag_ROB), .full_ROB(full_ROB),
    .valid_Result_add(valid_Result_add), .tag_ROB_add(tag_ROB_add),
    .mispredict_add(mispredict_add), .valid_Result_mul(valid_Result_mul),
    .tag_ROB_mul(tag_ROB_mul), .RegWr_ARF(RegWr_ARF), .tag_PRF_ARF(tag_PRF_ARF),
    .tag_Rw_old(tag_Rw_old), .ARF_tag(ARF_tag), .stop(stop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid_alloc = 1'b0; valid_Result_add = 1'b0; valid_Result_mul = 1'b0;
    mispredict_add = 1'b0; freeze_front = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic set_alloc(input logic rw_en, input int rw, input int tnew, input int told);
    valid_alloc = 1'b1; RegWr_alloc = rw_en; Rw_alloc = RW_W'(rw);
    tag_PRF_alloc = TAG_W'(tnew); tag_Rw_old_alloc = TAG_W'(told);
  endtask

  task automatic alloc1(input logic rw_en, input int rw, input int tnew, input int told);
    set_alloc(rw_en, rw, tnew, told);
    cyc();
    valid_alloc = 1'b0;
  endtask

  initial begin
    #12;
    for (int i = 0; i < AREG_N; i++) chk($sformatf("rst_arf%0d", i), ARF_tag[i], i);
    chk("rst_full", full_ROB, 0);
    chk("rst_tag_rob", tag_ROB, 0);
    chk("rst_stop", stop, 0);
    chk("rst_regwr", RegWr_ARF, 0);
    chk("rst_tag_prf", tag_PRF_ARF, 0);
    chk("rst_tag_old", tag_Rw_old, 0);
    rst = 1'b1;
    cyc();

    // In-order retire after out-of-order completion
    alloc1(1, 3, 8, 3);
    chk("a_tag_rob", tag_ROB, 1);
    alloc1(1, 3, 9, 8);
    chk("b_tag_rob", tag_ROB, 2);
    valid_Result_add = 1'b1; tag_ROB_add = 4'd1; cyc(); clr();
    chk("b_done_no_commit", RegWr_ARF, 0);
    valid_Result_mul = 1'b1; tag_ROB_mul = 4'd0; cyc(); clr();
    chk("a_regwr", RegWr_ARF, 1);
    chk("a_tag_new", tag_PRF_ARF, 8);
    chk("a_tag_old", tag_Rw_old, 3);
    cyc();
    chk("b_tag_new", tag_PRF_ARF, 9);
    chk("b_tag_old", tag_Rw_old, 8);
    chk("arf3_after_a", ARF_tag[3], 8);
    cyc();
    chk("arf3_after_b", ARF_tag[3], 9);
    chk("idle_regwr", RegWr_ARF, 0);

    // Non-writing instruction
    alloc1(0, 5, 20, 5);
    valid_Result_add = 1'b1; tag_ROB_add = 4'd2; cyc(); clr();
    chk("nw_regwr", RegWr_ARF, 0);
    chk("nw_tag_new", tag_PRF_ARF, 0);
    chk("nw_tag_old", tag_Rw_old, 5);
    cyc();
    chk("nw_arf5", ARF_tag[5], 5);
    chk("nw_tag_rob", tag_ROB, 3);

    // Mid-operation reset, then full/wrap
    do_reset();
    chk("mid_rst_arf3", ARF_tag[3], 3);
    chk("mid_rst_tag_rob", tag_ROB, 0);
    cyc();
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_not_full", full_ROB, 0);
      alloc1(1, i % AREG_N, i + 10, i);
    end
    chk("full_set", full_ROB, 1);
    chk("full_tag_rob", tag_ROB, 0);
    alloc1(1, 6, 31, 6);
    chk("full_17th_full", full_ROB, 1);
    chk("full_17th_tag_rob", tag_ROB, 0);
    valid_Result_add = 1'b1; tag_ROB_add = 4'd0; cyc(); clr();
    chk("full_head_tag_new", tag_PRF_ARF, 10);
    chk("full_head_tag_old", tag_Rw_old, 0);
    cyc();
    chk("after_commit_full", full_ROB, 0);
    chk("after_commit_arf0", ARF_tag[0], 10);
    chk("wrap_tag_rob", tag_ROB, 0);
    alloc1(1, 1, 30, 11);
    chk("wrap_full", full_ROB, 1);
    chk("wrap_tag_rob_after", tag_ROB, 1);

    // Mispredict flush
    do_reset();
    cyc();
    alloc1(1, 1, 12, 1);
    alloc1(1, 2, 13, 2);
    alloc1(1, 1, 14, 12);
    alloc1(1, 4, 15, 4);
    valid_Result_mul = 1'b1; tag_ROB_mul = 4'd0;
    valid_Result_add = 1'b1; tag_ROB_add = 4'd1; mispredict_add = 1'b1;
    cyc(); clr();
    chk("mp_e0_tag_new", tag_PRF_ARF, 12);
    chk("mp_e0_stop", stop, 0);
    cyc();
    chk("mp_e1_tag_new", tag_PRF_ARF, 13);
    chk("mp_e1_tag_old", tag_Rw_old, 2);
    set_alloc(1, 6, 27, 6);
    cyc();
    chk("mp_stop_hi", stop, 1);
    chk("mp_tag_rob", tag_ROB, 0);
    chk("mp_full", full_ROB, 0);
    chk("mp_regwr", RegWr_ARF, 0);
    chk("mp_arf1", ARF_tag[1], 12);
    chk("mp_arf2", ARF_tag[2], 13);
    chk("mp_arf4", ARF_tag[4], 4);
    set_alloc(1, 6, 26, 6);
    valid_Result_add = 1'b1; tag_ROB_add = 4'd2;
    cyc();
    valid_Result_add = 1'b0;
    chk("mp_stop_lo", stop, 0);
    chk("mp_stop_alloc_ignored", tag_ROB, 0);
    chk("mp_no_commit", RegWr_ARF, 0);
    set_alloc(1, 6, 16, 6);
    cyc(); clr();
    chk("post_stop_tag_rob", tag_ROB, 1);
    valid_Result_add = 1'b1; tag_ROB_add = 4'd0; cyc(); clr();
    chk("post_stop_idx0_new", tag_PRF_ARF, 16);
    chk("post_stop_idx0_old", tag_Rw_old, 6);
    cyc();
    chk("post_stop_arf6", ARF_tag[6], 16);

    // Simultaneous add+mul writeback
    do_reset();
    cyc();
    alloc1(1, 7, 17, 7);
    alloc1(1, 7, 18, 17);
    valid_Result_add = 1'b1; tag_ROB_add = 4'd0;
    valid_Result_mul = 1'b1; tag_ROB_mul = 4'd1;
    cyc(); clr();
    chk("dual_first_new", tag_PRF_ARF, 17);
    cyc();
    chk("dual_second_new", tag_PRF_ARF, 18);
    chk("dual_second_old", tag_Rw_old, 17);
    cyc();
    chk("dual_done_regwr", RegWr_ARF, 0);
    chk("dual_arf7", ARF_tag[7], 18);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rob.md
# rob

Reorder buffer and committed-map stage sitting directly downstream of writeback and feeding the physical register file's release and recovery paths. Allocates one entry per issued instruction in program order and marks entries done on add/mul writeback. Retires at most one done head entry per cycle, driving `RegWr_ARF`, `tag_PRF_ARF` and `tag_Rw_old` so the PRF can free the overwritten physical register. Holds the committed architectural map `ARF_tag[7:0]` and raises a one-cycle `stop` on a committed mispredict so the PRF rebuilds its free list.

## Interface
- `DEPTH`, 16, number of entries; power of two.
- `TAG_W`, 5, physical tag width.
- `AREG_N`, 8, number of architectural registers.
- `clk` in 1 clock, rising edge.
- `rst` in 1 asynchronous, active-low reset.
- `freeze_front` in 1 blocks allocation.
- `valid_alloc` in 1 allocate request for the instruction being issued.
- `RegWr_alloc` in 1 instruction writes a register.
- `Rw_alloc` in 3 architectural destination.
- `tag_PRF_alloc` in TAG_W new physical tag.
- `tag_Rw_old_alloc` in TAG_W previous mapping of `Rw_alloc`.
- `tag_ROB` out log2(DEPTH) index the next allocation will receive (tail).
- `full_ROB` out 1 count == DEPTH.
- `valid_Result_add` in 1 add writeback.
- `tag_ROB_add` in log2(DEPTH) entry completed by add.
- `mispredict_add` in 1 add result is a mispredicted branch.
- `valid_Result_mul` in 1 mul writeback.
- `tag_ROB_mul` in log2(DEPTH) entry completed by mul.
- `RegWr_ARF` out 1 committing entry writes a register.
- `tag_PRF_ARF` out TAG_W committing new tag.
- `tag_Rw_old` out TAG_W committing old tag, to be freed.
- `ARF_tag[AREG_N-1:0]` out TAG_W each, committed map.
- `stop` out 1 flush/recovery pulse.

## Operation
- Entry fields: valid, done, mispredict, RegWr, Rw, tag_new, tag_old. Head, tail pointers log2(DEPTH) wide, wrapping; count log2(DEPTH)+1 wide.
- Allocate: occurs when `valid_alloc && !freeze_front && !full_ROB && !stop`. Writes the entry at tail: valid=1, done=0. Increments tail.
- Writeback: `valid_Result_add` sets done at `tag_ROB_add` and loads `mispredict_add`. `valid_Result_mul` sets done at `tag_ROB_mul`. Both may fire in one cycle. Writeback to an invalid entry is ignored.
- Commit: occurs when the head entry is valid and done. The combinational outputs are:
  - `RegWr_ARF` = head.RegWr.
  - `tag_PRF_ARF` = RegWr ? head.tag_new : 0.
  - `tag_Rw_old` = head.tag_old.
  - On that edge: `ARF_tag[Rw] <= tag_new` if RegWr; the entry is cleared; head advances.
- Mispredict commit: a commit whose head has mispredict=1. At that edge:
  - Perform the normal commit and ARF update.
  - Clear every entry's valid bit.
  - Set head = tail = 0 and count = 0.
  - Drop any same-cycle allocation.
  - Set the `stop` register.
- `stop` is high for exactly one cycle. During `stop`, allocation and writeback are ignored and no commit occurs. `ARF_tag` is stable and already includes the mispredicted instruction.
- Count update: +1 on allocate, −1 on commit, unchanged when both occur. Full blocks allocation even if a commit happens the same cycle.

## Timing
- Reset values:
  - all entries invalid; head = tail = count = 0
  - `full_ROB` = 0, `tag_ROB` = 0, `stop` = 0
  - `RegWr_ARF` = 0, `tag_PRF_ARF` = 0, `tag_Rw_old` = 0
  - `ARF_tag[i] = i`
- Reset mid-operation discards all state immediately.
- Writeback to the head at edge N allows commit in cycle N+1 (outputs valid during N+1, state updates at edge N+2).
- Allocate at edge N: the entry is visible and `tag_ROB` has advanced in cycle N+1.
- `stop` rises the cycle after the mispredict commit edge and falls after one cycle. The first allocation is accepted the cycle after `stop` falls, into index 0.
- `full_ROB` and `tag_ROB` come from registers; commit outputs are combinational from the head entry.

## Structure
- `rob_pkg`: `rob_entry_t` struct, `DEPTH`/`TAG_W`/`AREG_N` constants, pointer and count widths.
- Sub-module `arf_map`: the `AREG_N`×`TAG_W` committed map with write port (`we`, `Rw`, `tag`), async reset to identity, and the flat `ARF_tag` output.

## Test plan
- Reset: check `ARF_tag[i]=i`, `full_ROB=0`, `tag_ROB=0`, `stop=0`, `RegWr_ARF=0`.
- In-order retire after out-of-order completion:
  - Stimulus: allocate A (Rw=3, new=8, old=3), then B (Rw=3, new=9, old=8); write back B, then A.
  - Required: A commits with `tag_Rw_old=3`, then B with `tag_Rw_old=8`; `ARF_tag[3]=9`.
- Full/wrap:
  - Stimulus: allocate 16 entries.
  - Required: `full_ROB=1`; a 17th `valid_alloc` is ignored.
  - Stimulus: commit one entry, then allocate.
  - Required: the new entry lands at index 0 and `full_ROB` is 1 again.
- Non-writing instruction: RegWr=0 commits with `RegWr_ARF=0`, `tag_PRF_ARF=0`; `ARF_tag` unchanged.
- Mispredict flush:
  - Stimulus: allocate 4 entries; mark entry 1 done with `mispredict_add=1`; entries 0 and 1 done.
  - Required: both commit in consecutive cycles, then `stop` is high one cycle, count=0, `tag_ROB=0`, and `ARF_tag` reflects entries 0–1 only.
- Simultaneous add+mul writeback to entries 0 and 1 in the same cycle: both commit in the next two cycles.
